// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 checker: strips the trailing CRC byte, forwards payload through a
// hold/output skid pair, and reports per-frame pass/fail. Macro CRC_CHK_ERRCNT_EN adds the error counter.
module crc8_frame_checker #(
    parameter logic [7:0] POLY     = 8'h07,
    parameter logic [7:0] INIT     = 8'h00,
    parameter logic [7:0] XOR_OUT  = 8'h00,
    parameter int         ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          s_data_i,
    input  logic                s_valid_i,
    input  logic                s_last_i,
    output logic                s_ready_o,
    output logic [7:0]          m_data_o,
    output logic                m_valid_o,
    output logic                m_last_o,
    input  logic                m_ready_i,
    output logic                frame_done_o,
    output logic                frame_ok_o,
    output logic [7:0]          crc_calc_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic [7:0] crc_q, crc_d;
    logic       h_valid_q, h_valid_d;
    logic [7:0] h_data_q, h_data_d;
    logic       m_valid_q, m_valid_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_last_q, m_last_d;
    logic       done_q, done_d;
    logic       ok_q, ok_d;
    logic [7:0] calc_q, calc_d;
    logic       accept;
    logic [7:0] crc_final;

    // H only ever spills into O when O is free, which s_ready_o already guarantees.
    assign s_ready_o = !h_valid_q || !m_valid_q || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign crc_final = crc_q ^ XOR_OUT;

    always_comb begin
        crc_d     = crc_q;
        h_valid_d = h_valid_q;
        h_data_d  = h_data_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        calc_d    = calc_q;

        if (m_valid_q && m_ready_i) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (h_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = h_data_q;
                m_last_d  = s_last_i;
            end
            if (!s_last_i) begin
                crc_d     = crc8_byte(crc_q, s_data_i);
                h_valid_d = 1'b1;
                h_data_d  = s_data_i;
            end else begin
                h_valid_d = 1'b0;
                done_d    = 1'b1;
                ok_d      = (crc_final == s_data_i);
                calc_d    = crc_final;
                crc_d     = INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q     <= INIT;
            h_valid_q <= 1'b0;
            h_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            calc_q    <= XOR_OUT ^ INIT;
        end else begin
            crc_q     <= crc_d;
            h_valid_q <= h_valid_d;
            h_data_q  <= h_data_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            calc_q    <= calc_d;
        end
    end

    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign m_last_o     = m_last_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign crc_calc_o   = calc_q;

`ifdef CRC_CHK_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                chk_fail;

    assign chk_fail = accept && s_last_i && (crc_final != s_data_i);

    // Saturates at all-ones rather than wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (chk_fail && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Receive-side CRC-8 checker that sits directly downstream of the CRC generator stage. It consumes a byte stream in which each frame ends with one CRC byte, recomputes CRC-8 over the payload, and forwards the payload with the CRC byte stripped. The last payload byte is re-flagged as last, and a pass/fail result is reported per frame. Payload flows through a two-register skid (hold and output) with full valid/ready backpressure.

## Interface
- POLY, 8'h07, generator polynomial; normal (non-reflected) form, implicit x^8.
- INIT, 8'h00, CRC register value at reset and at the start of every frame.
- XOR_OUT, 8'h00, value XORed onto the computed CRC before the compare.
- ERRCNT_W, 16, width of the error counter.
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_data_i  in  8  input byte; the byte flagged last is the CRC byte.
- s_valid_i  in  1  input byte valid.
- s_last_i  in  1  marks the CRC byte that ends the frame.
- s_ready_o  out  1  input ready.
- m_data_o  out  8  payload byte out.
- m_valid_o  out  1  output valid.
- m_last_o  out  1  marks the last payload byte of the frame.
- m_ready_i  in  1  downstream ready.
- frame_done_o  out  1  one-cycle pulse when a frame's check completes.
- frame_ok_o  out  1  1 = received CRC matched; held until the next frame_done_o.
- crc_calc_o  out  8  computed CRC (after XOR_OUT) of the last checked frame; held.
- err_cnt_o  out  ERRCNT_W  count of failed frames; saturates at all-ones.

## Operation
- An input beat is accepted when s_valid_i && s_ready_o.
- CRC update is MSB-first, one byte per accepted non-last beat: crc ^= byte, then 8 shift steps, each XORing in POLY when the shifted-out MSB is 1.
- Hold register H: {h_valid, h_data}. Output register O: {m_valid_o, m_data_o, m_last_o}.
- Accepted beat with s_last_i=0: update the CRC with the byte. If h_valid, move H into O with last=0. Then H ← byte.
- Accepted beat with s_last_i=1 (CRC byte): if h_valid, move H into O with last=1 and clear h_valid; otherwise there is no output, because the frame has zero payload. Compare (crc ^ XOR_OUT) with the byte, then reload crc ← INIT.
- A zero-payload frame compares INIT^XOR_OUT against the received byte.
- s_ready_o = !h_valid || !m_valid_o || m_ready_i. The output beat is released on m_valid_o && m_ready_i.
- O is loaded only when empty or being drained in the same cycle; O is never overwritten while m_valid_o=1 && m_ready_i=0.
- Simultaneous accept and drain in one cycle: O takes the new value and stays valid.
- Mismatch: frame_ok_o=0 and err_cnt_o increments, holding at max. Payload is forwarded regardless of the check result.
- Reset asserted mid-frame: all state clears immediately. The partial frame is lost and the next accepted byte starts a new frame.

## Timing
- Reset values: s_ready_o=1, m_valid_o=0, m_data_o=0, m_last_o=0, frame_done_o=0, frame_ok_o=0, crc_calc_o=XOR_OUT^INIT, err_cnt_o=0.
- The first payload byte appears on m_* only after the following byte is accepted: one clock after that accept, registered.
- The last payload byte appears one clock after the CRC byte is accepted, with m_last_o=1.
- frame_done_o, frame_ok_o and crc_calc_o update one clock after the CRC-byte accept. frame_done_o is high for exactly one cycle.
- err_cnt_o updates on that same edge.
- Back-to-back frames at full rate sustain 1 byte/clk with m_ready_i=1.

## Configuration
- CRC_CHK_ERRCNT_EN defined: the error counter is compiled in, as described above.
- Not defined: no counter flops; err_cnt_o is tied to 0. All other behaviour is identical.

## Test plan
- POLY=07, INIT=00: send AB, 58(last) → m_* emits AB with last=1; frame_done_o pulses; frame_ok_o=1; crc_calc_o=58.
- Send ASCII "123456789" then F4(last), with m_ready_i=1 → nine bytes out, last flag on 0x39, frame_ok_o=1, one frame_done_o pulse; then send AB, 59(last) → frame_ok_o=0, crc_calc_o=58, err_cnt_o=1.
- Zero-payload frame 00(last) → no m_valid_o; frame_done_o pulses; frame_ok_o=1.
- Hold m_ready_i=0 during "123456789" → s_ready_o drops after two bytes are buffered. Then random m_ready_i → output byte order intact, no loss or duplication, frame_ok_o=1.
- Assert reset_n=0 after "1234", release, then send AB, 58(last) → all outputs at reset values during reset; afterwards only AB is output and frame_ok_o=1.
- Compile without CRC_CHK_ERRCNT_EN and send a bad frame → frame_ok_o=0 and err_cnt_o stays 0.
